irq_pending_latch: RTL and testbench

IRQ_PENDING_LATCH -- requirements
Module: irq_pending_latch

---
 rtl/irq_pending_latch_pkg.sv | 12 +
 rtl/irq_pending_latch_req_edge_detect.sv | 36 +++
 rtl/irq_pending_latch.sv | 68 ++++++
 tb/tb_irq_pending_latch.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/irq_pending_latch_pkg.sv
// Shared constants for the interrupt pending latch and its edge detector.
package irq_pending_latch_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    // One-hot vector selecting the request line named by a binary index.
    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/irq_pending_latch_req_edge_detect.sv
// Per-bit capture-event generator: rising-edge detect or plain level pass-through.
module irq_pending_latch_req_edge_detect
    import irq_pending_latch_pkg::*;
#(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_in,
    output logic [NUM_REQ-1:0] capture
);

    logic [NUM_REQ-1:0] req_prev;

    // Remember last cycle's request lines; cleared by reset so a line held
    // high through reset is seen as a fresh edge in the first cycle after it.
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_prev <= '0;
        end else begin
            req_prev <= req_in;
        end
    end

    // Select edge or level capture.
    always_comb begin
        if (EDGE_MODE) begin
            capture = req_in & ~req_prev;
        end else begin
            capture = req_in;
        end
    end

endmodule

// File: rtl/irq_pending_latch.sv
// Latches interrupt requests until acknowledged, with masking, sticky
// per-bit overflow flags and an error pulse for acks to idle bits.
module irq_pending_latch
    import irq_pending_latch_pkg::*;
#(
    parameter int EDGE_MODE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_in,
    input  logic [NUM_REQ-1:0] mask,
    input  logic               ack,
    input  logic [IDX_W-1:0]   ack_idx,
    input  logic               ovf_clr,
    output logic [NUM_REQ-1:0] pending,
    output logic [NUM_REQ-1:0] req_out,
    output logic               any_req,
    output logic [NUM_REQ-1:0] overflow,
    output logic               ack_err
);

    logic [NUM_REQ-1:0] capture;
    logic [NUM_REQ-1:0] ack_vec;
    logic [NUM_REQ-1:0] ack_hit;
    logic [NUM_REQ-1:0] ovf_set;

    irq_pending_latch_req_edge_detect #(
        .EDGE_MODE (EDGE_MODE != 0)
    ) u_edge (
        .clk     (clk),
        .rst     (rst),
        .req_in  (req_in),
        .capture (capture)
    );

    // Decode the acknowledge and work out which bits overflow this cycle.
    // NOTE: every signal gets an unconditional assignment at the top of the
    // block, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        ack_vec = '0;
        if (ack) begin
            ack_vec = idx_onehot(ack_idx);
        end
        ack_hit = ack_vec & pending;
        // An ack to the same bit absorbs the repeat event: set wins, no overflow.
        ovf_set = capture & pending & ~ack_vec;
    end

    // Pending, overflow and ack-error registers. Capture wins over a clear on
    // the same bit, and a new overflow wins over ovf_clr on that bit.
    // NOTE: reset is synchronous and overrides every same-cycle event or ack,
    // so no stale ack_err pulse survives a mid-operation reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            overflow <= '0;
            ack_err  <= 1'b0;
        end else begin
            pending  <= (pending & ~ack_hit) | capture;
            overflow <= (ovf_clr ? '0 : overflow) | ovf_set;
            ack_err  <= ack & ~pending[ack_idx];
        end
    end

    assign req_out = pending & ~mask;
    assign any_req = |req_out;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Self-checking bench: one edge-mode and one level-mode instance share the
// same stimulus; each is compared against a per-bit behavioural model.
module tb_irq_pending_latch;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_in;
    logic [3:0] mask;
    logic       ack;
    logic [1:0] ack_idx;
    logic       ovf_clr;

    logic [3:0] pend_e, rout_e, ovf_e;
    logic       any_e, err_e;
    logic [3:0] pend_l, rout_l, ovf_l;
    logic       any_l, err_l;

    int total = 0;
    int bad   = 0;

    // Model state, index 0 = edge-mode instance, 1 = level-mode instance.
    bit m_pend [2][4];
    bit m_ovf  [2][4];
    bit m_prev [2][4];
    bit m_err  [2];

    always #5 clk = ~clk;

    irq_pending_latch #(.EDGE_MODE(1)) dut_edge (
        .clk(clk), .rst(rst), .req_in(req_in), .mask(mask), .ack(ack),
        .ack_idx(ack_idx), .ovf_clr(ovf_clr), .pending(pend_e), .req_out(rout_e),
        .any_req(any_e), .overflow(ovf_e), .ack_err(err_e)
    );

    irq_pending_latch #(.EDGE_MODE(0)) dut_level (
        .clk(clk), .rst(rst), .req_in(req_in), .mask(mask), .ack(ack),
        .ack_idx(ack_idx), .ovf_clr(ovf_clr), .pending(pend_l), .req_out(rout_l),
        .any_req(any_l), .overflow(ovf_l), .ack_err(err_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            bit old_pend [4];
            for (int i = 0; i < 4; i++) old_pend[i] = m_pend[m][i];
            if (rst) begin
                for (int i = 0; i < 4; i++) begin
                    m_pend[m][i] = 0;
                    m_ovf[m][i]  = 0;
                    m_prev[m][i] = 0;
                end
                m_err[m] = 0;
            end else begin
                m_err[m] = ack && !old_pend[ack_idx];
                for (int i = 0; i < 4; i++) begin
                    bit ev, acked;
                    ev    = req_in[i] && (m == 1 || !m_prev[m][i]);
                    acked = ack && (int'(ack_idx) == i);
                    if (ovf_clr) m_ovf[m][i] = 0;
                    if (ev) begin
                        if (old_pend[i] && !acked) m_ovf[m][i] = 1;
                        m_pend[m][i] = 1;
                    end else if (acked) begin
                        m_pend[m][i] = 0;
                    end
                    m_prev[m][i] = req_in[i];
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        for (int m = 0; m < 2; m++) begin
            logic [3:0] ep, ero, eo;
            logic       ea;
            ea = 1'b0;
            for (int i = 0; i < 4; i++) begin
                ep[i]  = m_pend[m][i];
                eo[i]  = m_ovf[m][i];
                ero[i] = m_pend[m][i] && !mask[i];
                if (ero[i]) ea = 1'b1;
            end
            check($sformatf("%s/m%0d/pending", tag, m),  m == 0 ? pend_e : pend_l, ep);
            check($sformatf("%s/m%0d/req_out", tag, m),  m == 0 ? rout_e : rout_l, ero);
            check($sformatf("%s/m%0d/any_req", tag, m),  m == 0 ? any_e  : any_l,  ea);
            check($sformatf("%s/m%0d/overflow", tag, m), m == 0 ? ovf_e  : ovf_l,  eo);
            check($sformatf("%s/m%0d/ack_err", tag, m),  m == 0 ? err_e  : err_l,  m_err[m]);
        end
    endtask

    task automatic cyc(input logic [3:0] r, input logic [3:0] mk, input logic a,
                       input logic [1:0] ai, input logic oc, input logic rs,
                       input string tag);
        req_in  = r;
        mask    = mk;
        ack     = a;
        ack_idx = ai;
        ovf_clr = oc;
        rst     = rs;
        @(posedge clk);
        #1;
        model_step();
        compare_all(tag);
    endtask

    initial begin
        req_in = '0; mask = '0; ack = 0; ack_idx = '0; ovf_clr = 0; rst = 1;

        // Reset state
        cyc(4'b0000, 4'b0000, 0, 2'd0, 0, 1, "rst0");
        cyc(4'b0000, 4'b0000, 0, 2'd0, 0, 1, "rst1");
        check("rst_pending", pend_e, 4'b0000);
        check("rst_ack_err", err_e, 1'b0);

        // Single rising edge latches, then ack clears
        cyc(4'b0000, 4'b0000, 0, 2'd0, 0, 0, "r31a");
        cyc(4'b0100, 4'b0000, 0, 2'd0, 0, 0, "r31b");
        check("r31_pending", pend_e, 4'b0100);
        check("r31_req_out", rout_e, 4'b0100);
        check("r31_any_req", any_e, 1'b1);
        cyc(4'b0000, 4'b0000, 1, 2'd2, 0, 0, "r31c");
        check("r31_cleared", pend_e, 4'b0000);

        // Repeat event on pending bit sets overflow; ovf_clr clears it
        cyc(4'b0010, 4'b0000, 0, 2'd0, 0, 0, "r32a");
        cyc(4'b0000, 4'b0000, 0, 2'd0, 0, 0, "r32b");
        cyc(4'b0010, 4'b0000, 0, 2'd0, 0, 0, "r32c");
        check("r32_overflow", ovf_e, 4'b0010);
        cyc(4'b0000, 4'b0000, 0, 2'd0, 1, 0, "r32d");
        check("r32_ovf_clr", ovf_e, 4'b0000);
        cyc(4'b0000, 4'b0000, 1, 2'd1, 0, 0, "r32e");

        // Event and ack on the same bit: set wins, no overflow, no error
        cyc(4'b1000, 4'b0000, 0, 2'd0, 0, 0, "r33a");
        cyc(4'b0000, 4'b0000, 0, 2'd0, 0, 0, "r33b");
        cyc(4'b1000, 4'b0000, 1, 2'd3, 0, 0, "r33c");
        check("r33_pending", pend_e, 4'b1000);
        check("r33_overflow", ovf_e, 4'b0000);
        check("r33_ack_err", err_e, 1'b0);
        cyc(4'b0000, 4'b0000, 1, 2'd3, 0, 0, "r33d");

        // Ack to an idle bit pulses ack_err for one cycle only
        cyc(4'b0001, 4'b0000, 0, 2'd0, 0, 0, "r34a");
        cyc(4'b0000, 4'b0000, 1, 2'd2, 0, 0, "r34b");
        check("r34_ack_err", err_e, 1'b1);
        check("r34_pending", pend_e, 4'b0001);
        cyc(4'b0000, 4'b0000, 0, 2'd0, 0, 0, "r34c");
        check("r34_err_drop", err_e, 1'b0);
        cyc(4'b0000, 4'b0000, 1, 2'd0, 0, 0, "r34d");

        // Masked bits still latch; unmasking exposes them without a clock
        cyc(4'b1010, 4'b1111, 0, 2'd0, 0, 0, "r35a");
        check("r35_pending", pend_e, 4'b1010);
        check("r35_req_out", rout_e, 4'b0000);
        check("r35_any_req", any_e, 1'b0);
        mask = 4'b0000;
        #1;
        check("r35_unmask", rout_e, 4'b1010);
        compare_all("r35b");
        cyc(4'b0000, 4'b1111, 1, 2'd1, 0, 0, "r35c");
        cyc(4'b0000, 4'b0000, 1, 2'd3, 0, 0, "r35d");

        // Reset overrides everything; level-held request captured after reset
        cyc(4'b1111, 4'b0000, 0, 2'd0, 0, 0, "r36a");
        cyc(4'b0000, 4'b0000, 0, 2'd0, 0, 0, "r36b");
        cyc(4'b0101, 4'b0000, 0, 2'd0, 0, 0, "r36c");
        check("r36_pre_pend", pend_e, 4'b1111);
        check("r36_pre_ovf", ovf_e, 4'b0101);
        cyc(4'b1010, 4'b0000, 1, 2'd0, 0, 1, "r36d");
        check("r36_rst_pend", pend_e, 4'b0000);
        check("r36_rst_ovf", ovf_e, 4'b0000);
        check("r36_rst_err", err_e, 1'b0);
        check("r36_rst_any", any_e, 1'b0);
        cyc(4'b0011, 4'b0000, 0, 2'd0, 0, 1, "r36e");
        cyc(4'b0011, 4'b0000, 0, 2'd0, 0, 0, "r36f");
        check("r36_level_pend", pend_l, 4'b0011);
        check("r36_edge_pend", pend_e, 4'b0011);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            cyc(4'($urandom), 4'($urandom), ($urandom_range(0, 1) == 1),
                2'($urandom), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 49) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
